decode_stage: RTL

RV32I decode stage of the five-stage always-untaken pipeline. It consumes the registered instruction word from the fetch/decode register and the matching PC. It contains the 32×32 register file, written by writeback with write-through bypass, plus control decode and immediate generation. Its results are registered into the ID/EX pipeline register, which feeds the execute stage and the forwarding unit.

---
 rtl/rv32i_pkg.sv | 73 +++++++
 rtl/regfile.sv | 39 +++
 rtl/decode_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU operations, writeback select, opcodes and the
// packed ID/EX pipeline register layout.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD      = 4'd0,
        ALU_SUB      = 4'd1,
        ALU_SLL      = 4'd2,
        ALU_SLT      = 4'd3,
        ALU_SLTU     = 4'd4,
        ALU_XOR      = 4'd5,
        ALU_SRL      = 4'd6,
        ALU_SRA      = 4'd7,
        ALU_OR       = 4'd8,
        ALU_AND      = 4'd9,
        ALU_LUI_PASS = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        opa_sel;
        logic        opb_sel;
        logic        reg_wen;
        logic        mem_wen;
        logic        mem_ren;
        logic [2:0]  funct3;
        wb_sel_e     wb_sel;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } idex_t;

    // alt selects SUB (funct3=000) or SRA/SRAI (funct3=101) from instr[30].
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two read ports with write-through bypass, one write port.
// x0 is hard-wired to zero; reset clears every entry.
module regfile
    import rv32i_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i
);

    logic [31:0] regs_q [32];
    logic        wr_valid;

    assign wr_valid = wb_en_i && (wb_rd_i != 5'd0);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 : regs_q[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 : regs_q[rs2_addr_i];
        if (wr_valid && (wb_rd_i == rs1_addr_i)) rs1_data_o = wb_data_i;
        if (wr_valid && (wb_rd_i == rs2_addr_i)) rs2_data_o = wb_data_i;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file read, control decode, immediate generation
// and the ID/EX pipeline register (stall beats flush).
module decode_stage
    import rv32i_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_decode,
    input  logic        i_stall_execute,
    input  logic        i_flush_execute,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic [4:0]  o_rs1_addr_d,
    output logic [4:0]  o_rs2_addr_d,
    output logic [31:0] o_pc_ex,
    output logic [31:0] o_rs1_data_ex,
    output logic [31:0] o_rs2_data_ex,
    output logic [31:0] o_imm_ex,
    output logic [4:0]  o_rs1_addr_ex,
    output logic [4:0]  o_rs2_addr_ex,
    output logic [4:0]  o_rd_ex,
    output logic [3:0]  o_alu_op_ex,
    output logic        o_opa_sel_ex,
    output logic        o_opb_sel_ex,
    output logic        o_reg_wen_ex,
    output logic        o_mem_wen_ex,
    output logic        o_mem_ren_ex,
    output logic [2:0]  o_funct3_ex,
    output logic [1:0]  o_wb_sel_ex,
    output logic        o_branch_ex,
    output logic        o_jal_ex,
    output logic        o_jalr_ex,
    output logic        o_illegal_ex
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_rd_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    idex_t       idex_d, idex_q;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];

    assign o_rs1_addr_d = i_instr[19:15];
    assign o_rs2_addr_d = i_instr[24:20];

    // LUI reads x0 so that rs1 + imm yields the upper immediate on the ALU adder.
    assign rs1_rd_addr = (opcode == OPC_LUI) ? 5'd0 : i_instr[19:15];

    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'd0};
    assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    regfile u_regfile (
        .clk_i      (i_clk),
        .reset_ni   (i_reset),
        .rs1_addr_i (rs1_rd_addr),
        .rs2_addr_i (i_instr[24:20]),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .wb_en_i    (i_wb_en),
        .wb_rd_i    (i_wb_rd),
        .wb_data_i  (i_wb_data)
    );

    always_comb begin
        idex_d          = '0;
        idex_d.pc       = i_pc_decode;
        idex_d.rs1_data = rs1_data;
        idex_d.rs2_data = rs2_data;
        idex_d.rs1_addr = rs1_rd_addr;
        idex_d.rd       = i_instr[11:7];
        case (opcode)
            OPC_LUI: begin
                idex_d.imm = imm_u; idex_d.opb_sel = 1'b1; idex_d.reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                idex_d.imm = imm_u; idex_d.opa_sel = 1'b1; idex_d.opb_sel = 1'b1;
                idex_d.reg_wen = 1'b1;
            end
            OPC_JAL: begin
                idex_d.imm = imm_j; idex_d.opa_sel = 1'b1; idex_d.opb_sel = 1'b1;
                idex_d.reg_wen = 1'b1; idex_d.wb_sel = WB_PC4; idex_d.jal = 1'b1;
            end
            OPC_JALR: begin
                idex_d.imm = imm_i; idex_d.opb_sel = 1'b1; idex_d.reg_wen = 1'b1;
                idex_d.wb_sel = WB_PC4; idex_d.jalr = 1'b1; idex_d.funct3 = funct3;
            end
            OPC_BRANCH: begin
                idex_d.imm = imm_b; idex_d.rs2_addr = i_instr[24:20]; idex_d.rd = '0;
                idex_d.alu_op = ALU_SUB; idex_d.branch = 1'b1; idex_d.funct3 = funct3;
            end
            OPC_LOAD: begin
                idex_d.imm = imm_i; idex_d.opb_sel = 1'b1; idex_d.reg_wen = 1'b1;
                idex_d.mem_ren = 1'b1; idex_d.wb_sel = WB_MEM; idex_d.funct3 = funct3;
            end
            OPC_STORE: begin
                idex_d.imm = imm_s; idex_d.rs2_addr = i_instr[24:20]; idex_d.rd = '0;
                idex_d.opb_sel = 1'b1; idex_d.mem_wen = 1'b1; idex_d.funct3 = funct3;
            end
            OPC_OP_IMM: begin
                idex_d.imm = imm_i; idex_d.opb_sel = 1'b1; idex_d.reg_wen = 1'b1;
                idex_d.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && i_instr[30]);
                idex_d.funct3 = funct3;
            end
            OPC_OP: begin
                idex_d.rs2_addr = i_instr[24:20]; idex_d.reg_wen = 1'b1;
                idex_d.alu_op = alu_from_funct3(funct3, i_instr[30]);
                idex_d.funct3 = funct3;
            end
            default: begin
                // All-zero word is a pipeline bubble, not an illegal instruction.
                idex_d.rd      = '0;
                idex_d.illegal = (i_instr != 32'd0);
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idex_q <= '0;
        end else if (i_stall_execute) begin
            idex_q <= idex_q;
        end else if (i_flush_execute) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign o_pc_ex       = idex_q.pc;
    assign o_rs1_data_ex = idex_q.rs1_data;
    assign o_rs2_data_ex = idex_q.rs2_data;
    assign o_imm_ex      = idex_q.imm;
    assign o_rs1_addr_ex = idex_q.rs1_addr;
    assign o_rs2_addr_ex = idex_q.rs2_addr;
    assign o_rd_ex       = idex_q.rd;
    assign o_alu_op_ex   = idex_q.alu_op;
    assign o_opa_sel_ex  = idex_q.opa_sel;
    assign o_opb_sel_ex  = idex_q.opb_sel;
    assign o_reg_wen_ex  = idex_q.reg_wen;
    assign o_mem_wen_ex  = idex_q.mem_wen;
    assign o_mem_ren_ex  = idex_q.mem_ren;
    assign o_funct3_ex   = idex_q.funct3;
    assign o_wb_sel_ex   = idex_q.wb_sel;
    assign o_branch_ex   = idex_q.branch;
    assign o_jal_ex      = idex_q.jal;
    assign o_jalr_ex     = idex_q.jalr;
    assign o_illegal_ex  = idex_q.illegal;

endmodule
